// File: rtl/rotor_3_reverse.sv
// rtl/rotor_3_reverse.sv - Enigma rotor 3 return path: inverse substitution with stepping position.
// One registered output stage behind a valid/ready handshake; carry pulses on the 25->0 wrap.
module rotor_3_reverse #(
  parameter int                 CHAR_W  = 8,
  parameter int                 ALPHA   = 26,
  parameter logic [CHAR_W-1:0]  UNKNOWN = 8'h3F
) (
  input  logic              signal,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CHAR_W-1:0] in_char,
  input  logic              load,
  input  logic [4:0]        start_pos,
  input  logic              step_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHAR_W-1:0] out_char,
  output logic [4:0]        pos,
  output logic              carry_out
);

  localparam logic [CHAR_W-1:0] UP_A    = CHAR_W'(8'h41);
  localparam logic [CHAR_W-1:0] UP_Z    = CHAR_W'(8'h5A);
  localparam logic [CHAR_W-1:0] LO_A    = CHAR_W'(8'h61);
  localparam logic [CHAR_W-1:0] LO_Z    = CHAR_W'(8'h7A);
  localparam logic signed [5:0] ALPHA_S = 6'(ALPHA);
  localparam logic [4:0]        POS_MAX = 5'(ALPHA - 1);

  logic              out_valid_q, out_valid_d;
  logic [CHAR_W-1:0] out_char_q, out_char_d;
  logic [4:0]        pos_q, pos_d;
  logic              carry_q, carry_d;

  logic              accept;
  logic              is_upper, is_lower;
  logic [4:0]        letter_idx;
  logic signed [5:0] diff_raw, diff_mod, shift_raw;
  logic [4:0]        sub_idx;
  logic [CHAR_W-1:0] sub_char;

  always_comb begin
    in_ready = !out_valid_q || out_ready;
    accept   = in_valid && in_ready;

    is_upper = (in_char >= UP_A) && (in_char <= UP_Z);
    is_lower = (in_char >= LO_A) && (in_char <= LO_Z);
    // 'A' and 'a' both have low five bits 00001, so one subtract serves both cases.
    letter_idx = in_char[4:0] - 5'd1;

    // (j - p) first, folded into 0..25, then the fixed 1/2 offset folded again.
    diff_raw  = $signed({1'b0, letter_idx}) - $signed({1'b0, pos_q});
    diff_mod  = (diff_raw < 0) ? diff_raw + ALPHA_S : diff_raw;
    shift_raw = diff_mod - (is_upper ? 6'sd2 : 6'sd1);
    sub_idx   = (shift_raw < 0) ? 5'(shift_raw + ALPHA_S) : 5'(shift_raw);

    if (is_lower) begin
      sub_char = UP_A + CHAR_W'(sub_idx);
    end else if (is_upper) begin
      sub_char = LO_A + CHAR_W'(sub_idx);
    end else begin
      sub_char = UNKNOWN;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_char_d  = out_char_q;
    pos_d       = pos_q;
    carry_d     = 1'b0;

    if (accept) begin
      out_valid_d = 1'b1;
      out_char_d  = sub_char;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Load wins over stepping; the accepted character above already used the old pos.
    if (load) begin
      pos_d = (start_pos > POS_MAX) ? 5'd0 : start_pos;
    end else if (accept && step_en) begin
      if (pos_q == POS_MAX) begin
        pos_d   = 5'd0;
        carry_d = 1'b1;
      end else begin
        pos_d = pos_q + 5'd1;
      end
    end
  end

  always_ff @(posedge signal) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_char_q  <= '0;
      pos_q       <= 5'd0;
      carry_q     <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_char_q  <= out_char_d;
      pos_q       <= pos_d;
      carry_q     <= carry_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_char  = out_char_q;
  assign pos       = pos_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_rotor_3_reverse.sv
// tb/tb_rotor_3_reverse.sv - self-checking bench for rotor_3_reverse.
// Behavioural model updated on each rising edge; outputs compared every falling edge.
module tb_rotor_3_reverse;

  logic       signal = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_char = 8'h00;
  logic       load = 1'b0;
  logic [4:0] start_pos = 5'd0;
  logic       step_en = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_char;
  logic [4:0] pos;
  logic       carry_out;

  rotor_3_reverse dut (
    .signal    (signal),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .load      (load),
    .start_pos (start_pos),
    .step_en   (step_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .pos       (pos),
    .carry_out (carry_out)
  );

  initial forever #5 signal = ~signal;

  int   n_total  = 0;
  int   n_passed = 0;
  bit   chk_en   = 1'b0;

  int       m_pos   = 0;
  bit       m_valid = 1'b0;
  bit       m_carry = 1'b0;
  logic [7:0] m_char = 8'h00;

  function automatic logic [7:0] ref_sub(input logic [7:0] c, input int p);
    int j;
    if (c >= 8'h61 && c <= 8'h7A) begin
      j = int'(c) - 97;
      return 8'(65 + (((j - 1 - p) % 26) + 26) % 26);
    end else if (c >= 8'h41 && c <= 8'h5A) begin
      j = int'(c) - 65;
      return 8'(97 + (((j - 2 - p) % 26) + 26) % 26);
    end
    return 8'h3F;
  endfunction

  always @(posedge signal) begin
    bit acc;
    acc = in_valid && (!m_valid || out_ready);
    if (rst) begin
      m_pos = 0; m_valid = 1'b0; m_char = 8'h00; m_carry = 1'b0;
    end else begin
      m_carry = 1'b0;
      if (acc) begin
        m_char  = ref_sub(in_char, m_pos);
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (load) begin
        m_pos = (int'(start_pos) > 25) ? 0 : int'(start_pos);
      end else if (acc && step_en) begin
        m_pos   = (m_pos + 1) % 26;
        m_carry = (m_pos == 0);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic compare_all();
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    chk("pos", 32'(pos), 32'(m_pos));
    chk("carry_out", 32'(carry_out), 32'(m_carry));
    if (m_valid) chk("out_char", 32'(out_char), 32'(m_char));
  endtask

  // Falling-edge compare of the state left by the previous rising edge, then the next edge.
  task automatic tick();
    @(negedge signal);
    if (chk_en) compare_all();
    @(posedge signal);
    #1;
  endtask

  task automatic drive(input bit v, input logic [7:0] c, input bit ld, input logic [4:0] sp,
                       input bit se, input bit ordy);
    in_valid = v; in_char = c; load = ld; start_pos = sp; step_en = se; out_ready = ordy;
  endtask

  logic [7:0] edge_chars [8] = '{8'h40, 8'h41, 8'h5A, 8'h5B, 8'h60, 8'h61, 8'h7A, 8'h7B};

  initial begin
    rst = 1'b1;
    drive(0, 8'h00, 0, 5'd0, 0, 0);
    tick(); tick();
    rst = 1'b0;
    chk("rst_pos", 32'(pos), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_char", 32'(out_char), 32'h00);
    chk("rst_carry", 32'(carry_out), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk_en = 1'b1;

    // Basic substitution with stepping.
    drive(1, 8'h62, 0, 5'd0, 1, 1); tick();
    chk("b_at_p0", 32'(out_char), 32'h41);
    chk("b_valid", 32'(out_valid), 32'd1);
    chk("pos_after_1", 32'(pos), 32'd1);
    drive(1, 8'h41, 0, 5'd0, 1, 1); tick();
    chk("pos_after_2", 32'(pos), 32'd2);

    // Load 3, no stepping.
    drive(0, 8'h00, 1, 5'd3, 0, 1); tick();
    drive(1, 8'h62, 0, 5'd0, 0, 1); tick();
    chk("b_at_p3", 32'(out_char), 32'h58);
    chk("pos_hold_3", 32'(pos), 32'd3);
    drive(1, 8'h31, 0, 5'd0, 0, 1); tick();
    chk("nonletter", 32'(out_char), 32'h3F);

    // Wrap 25 -> 0 with carry.
    drive(0, 8'h00, 1, 5'd25, 0, 1); tick();
    drive(1, 8'h62, 0, 5'd0, 1, 1); tick();
    chk("wrap_pos", 32'(pos), 32'd0);
    chk("wrap_carry", 32'(carry_out), 32'd1);
    drive(1, 8'h41, 0, 5'd0, 0, 1); tick();
    chk("carry_one_cycle", 32'(carry_out), 32'd0);
    chk("A_at_p0", 32'(out_char), 32'h79);
    // Load in the accept cycle: old pos 25 used, no step, no carry.
    drive(0, 8'h00, 1, 5'd25, 0, 1); tick();
    drive(1, 8'h62, 1, 5'd25, 1, 1); tick();
    chk("load_accept_pos", 32'(pos), 32'd25);
    chk("load_accept_carry", 32'(carry_out), 32'd0);
    chk("b_at_p25", 32'(out_char), 32'h42);
    drive(0, 8'h00, 1, 5'd30, 0, 1); tick();
    chk("load_oob", 32'(pos), 32'd0);

    // Backpressure hold.
    drive(1, 8'h62, 0, 5'd0, 0, 0); tick();
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    drive(1, 8'h63, 0, 5'd0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_char", 32'(out_char), 32'h41);
    end
    chk("bp_no_step", 32'(pos), 32'd0);
    drive(0, 8'h00, 0, 5'd0, 0, 1); #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    chk("bp_drained", 32'(out_valid), 32'd0);

    // Reset while holding.
    drive(0, 8'h00, 1, 5'd7, 0, 1); tick();
    drive(1, 8'h62, 0, 5'd0, 1, 0); tick();
    rst = 1'b1;
    drive(1, 8'h63, 0, 5'd0, 1, 0); tick();
    rst = 1'b0;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_pos", 32'(pos), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] c;
      case ($urandom_range(0, 3))
        0: c = 8'(8'h41 + $urandom_range(0, 25));
        1: c = 8'(8'h61 + $urandom_range(0, 25));
        2: c = 8'($urandom_range(0, 255));
        default: c = edge_chars[$urandom_range(0, 7)];
      endcase
      rst = ($urandom_range(0, 127) == 0);
      drive($urandom_range(0, 3) != 0, c, $urandom_range(0, 15) == 0,
            5'($urandom_range(0, 31)), $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;
    drive(0, 8'h00, 0, 5'd0, 0, 1);
    tick();

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
